// File: rtl/extend_pipe.sv
// Immediate extender with a 2-entry output FIFO: the immediate is formed at
// accept time and buffered so the consumer can stall without stalling decode.
module extend_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_err
);

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_BAD = 3'd7
  } imm_type_e;

  function automatic imm_type_e decode_opcode(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      7'h03, 7'h13, 7'h67, 7'h73: t = IMM_I;
      7'h23:                      t = IMM_S;
      7'h63:                      t = IMM_B;
      7'h37, 7'h17:               t = IMM_U;
      7'h6F:                      t = IMM_J;
      default:                    t = IMM_BAD;
    endcase
    return t;
  endfunction

  function automatic imm_type_e decode_sel(input logic [2:0] s);
    imm_type_e t;
    case (s)
      3'd0:    t = IMM_I;
      3'd1:    t = IMM_S;
      3'd2:    t = IMM_B;
      3'd3:    t = IMM_U;
      3'd4:    t = IMM_J;
      default: t = IMM_BAD;
    endcase
    return t;
  endfunction

  // Always built at 64 bits; the XLEN=32 variant keeps the low half.
  function automatic logic [63:0] extend_imm(input imm_type_e t, input logic [31:0] w);
    logic [63:0] imm;
    case (t)
      IMM_I:   imm = {{52{w[31]}}, w[31:20]};
      IMM_S:   imm = {{52{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm = {{32{w[31]}}, w[31:12], 12'h000};
      IMM_J:   imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = 64'h0;
    endcase
    return imm;
  endfunction

  imm_type_e       type_s;
  logic [63:0]     imm_full_s;
  logic            err_s;
  logic            push_s;
  logic            pop_s;
  logic            unused_bits_s;

  logic [XLEN-1:0] imm_mem_r [2];
  logic            err_mem_r [2];
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [1:0]      count_r;

  // Ready depends only on occupancy (and is held low during reset), never on out_ready.
  assign in_ready  = !rst && (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_imm   = imm_mem_r[rd_ptr_r];
  assign out_err   = err_mem_r[rd_ptr_r];

  assign unused_bits_s = ^{imm_full_s, instr[6:0], sel};

  // Type selection, extension and handshake decode.
  always_comb begin
    type_s = IMM_BAD;
    if (AUTO_DECODE != 32'sd0) begin
      type_s = decode_opcode(instr[6:0]);
    end else begin
      type_s = decode_sel(sel);
    end
    imm_full_s = extend_imm(type_s, instr);
    err_s      = (type_s == IMM_BAD);
    push_s     = in_valid && in_ready;
    pop_s      = out_valid && out_ready;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      imm_mem_r[0] <= {XLEN{1'b0}};
      imm_mem_r[1] <= {XLEN{1'b0}};
      err_mem_r[0] <= 1'b0;
      err_mem_r[1] <= 1'b0;
    end else if (flush) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        imm_mem_r[wr_ptr_r] <= imm_full_s[XLEN-1:0];
        err_mem_r[wr_ptr_r] <= err_s;
        wr_ptr_r            <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench: dut_a is XLEN=32 with sel decode, dut_b is XLEN=64 with opcode decode.
module tb_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0;
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_instr = 32'h0;
  logic [2:0]  a_sel = 3'd0;
  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_imm;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_instr = 32'h0;
  logic [2:0]  b_sel = 3'd7;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_imm;

  extend_pipe #(.XLEN(32), .AUTO_DECODE(0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_imm(a_out_imm), .out_err(a_out_err));

  extend_pipe #(.XLEN(64), .AUTO_DECODE(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .sel(b_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_imm(b_out_imm), .out_err(b_out_err));

  typedef struct {
    logic [63:0] imm;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: compare head against scoreboard while valid, pop on transfer.
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      if (q_a.size() == 0) begin
        check("a_spurious_valid", {63'd0, a_out_valid}, 64'd0);
      end else begin
        check("a_imm", {32'd0, a_out_imm}, {32'd0, q_a[0].imm[31:0]});
        check("a_err", {63'd0, a_out_err}, {63'd0, q_a[0].err});
        if (a_out_ready) begin
          if (q_a[0].chk_lat) check("a_latency", 64'(cyc), 64'(q_a[0].acc_cyc + 1));
          void'(q_a.pop_front());
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      if (q_b.size() == 0) begin
        check("b_spurious_valid", {63'd0, b_out_valid}, 64'd0);
      end else begin
        check("b_imm", b_out_imm, q_b[0].imm);
        check("b_err", {63'd0, b_out_err}, {63'd0, q_b[0].err});
        if (b_out_ready) begin
          if (q_b[0].chk_lat) check("b_latency", 64'(cyc), 64'(q_b[0].acc_cyc + 1));
          void'(q_b.pop_front());
        end
      end
    end
  end

  task automatic offer_a(input logic [31:0] w, input logic [2:0] s, input logic [63:0] e_imm,
                         input logic e_err, input bit lat, output bit acc);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_instr = w; a_sel = s;
    @(negedge clk);
    acc = a_in_ready;
    #1;
    if (acc && !flush && !rst) q_a.push_back('{e_imm, e_err, cyc, lat});
  endtask

  task automatic offer_b(input logic [31:0] w, input logic [63:0] e_imm, input logic e_err);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_instr = w;
    @(negedge clk);
    check("b_accept", {63'd0, b_in_ready}, 64'd1);
    #1;
    if (b_in_ready) q_b.push_back('{e_imm, e_err, cyc, 1'b1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_in_valid = 1'b0; b_in_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] w;
    logic [2:0]  s;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  vec_t basic[7] = '{
    '{32'hFFC4A303, 3'd0, 64'hFFFFFFFC, 1'b0},
    '{32'h0064A423, 3'd1, 64'h00000008, 1'b0},
    '{32'hFE420AE3, 3'd2, 64'hFFFFFFF4, 1'b0},
    '{32'h12345037, 3'd3, 64'h12345000, 1'b0},
    '{32'h008000EF, 3'd4, 64'h00000008, 1'b0},
    '{32'hFFC4A303, 3'd5, 64'h00000000, 1'b1},
    '{32'h12345037, 3'd7, 64'h00000000, 1'b1}
  };

  vec_t stream[8] = '{
    '{32'h00100093, 3'd0, 64'h00000001, 1'b0},
    '{32'h7FF00093, 3'd0, 64'h000007FF, 1'b0},
    '{32'h80000093, 3'd0, 64'hFFFFF800, 1'b0},
    '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 1'b0},
    '{32'h80000037, 3'd3, 64'h80000000, 1'b0},
    '{32'hFE000FA3, 3'd1, 64'hFFFFFFFF, 1'b0},
    '{32'h80000063, 3'd2, 64'hFFFFF000, 1'b0},
    '{32'h800000EF, 3'd4, 64'hFFF00000, 1'b0}
  };

  vec_t auto_vecs[6] = '{
    '{32'hFFC4A303, 3'd0, 64'hFFFFFFFFFFFFFFFC, 1'b0},
    '{32'h0000007F, 3'd0, 64'h0000000000000000, 1'b1},
    '{32'h80000037, 3'd0, 64'hFFFFFFFF80000000, 1'b0},
    '{32'h0064A423, 3'd0, 64'h0000000000000008, 1'b0},
    '{32'h008000EF, 3'd0, 64'h0000000000000008, 1'b0},
    '{32'h00000033, 3'd0, 64'h0000000000000000, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_in_ready_in_rst", {63'd0, a_in_ready}, 64'd0);
    check("a_out_valid_rst", {63'd0, a_out_valid}, 64'd0);
    check("a_out_imm_rst", {32'd0, a_out_imm}, 64'd0);
    check("a_out_err_rst", {63'd0, a_out_err}, 64'd0);
    check("b_out_imm_rst", b_out_imm, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_in_ready_after_rst", {63'd0, a_in_ready}, 64'd1);
    check("b_in_ready_after_rst", {63'd0, b_in_ready}, 64'd1);

    // Opcode-decoded 64-bit variant; sel held at an illegal value to show it is ignored
    foreach (auto_vecs[i]) offer_b(auto_vecs[i].w, auto_vecs[i].imm, auto_vecs[i].err);
    idle(3);

    // All five types plus illegal sel, back to back
    a_out_ready = 1'b1;
    foreach (basic[i]) begin
      offer_a(basic[i].w, basic[i].s, basic[i].imm, basic[i].err, 1'b1, acc);
      check("a_accept_basic", {63'd0, acc}, 64'd1);
    end
    idle(3);
    @(negedge clk);
    check("a_idle_out_valid", {63'd0, a_out_valid}, 64'd0);

    // Eight-beat stream at one beat per cycle
    foreach (stream[i]) begin
      offer_a(stream[i].w, stream[i].s, stream[i].imm, stream[i].err, 1'b1, acc);
      check("a_stream_in_ready", {63'd0, acc}, 64'd1);
    end
    idle(3);

    // Backpressure: third beat refused, then in-order drain
    a_out_ready = 1'b0;
    offer_a(32'h00500013, 3'd0, 64'h5, 1'b0, 1'b0, acc);
    check("a_bp_accept1", {63'd0, acc}, 64'd1);
    offer_a(32'h00600013, 3'd0, 64'h6, 1'b0, 1'b0, acc);
    check("a_bp_accept2", {63'd0, acc}, 64'd1);
    offer_a(32'h00700013, 3'd0, 64'h7, 1'b0, 1'b0, acc);
    check("a_bp_full_in_ready", {63'd0, acc}, 64'd0);
    idle(2);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("a_drain_valid1", {63'd0, a_out_valid}, 64'd1);
    @(negedge clk);
    check("a_drain_valid2", {63'd0, a_out_valid}, 64'd1);
    check("a_drain_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    check("a_drain_empty", {63'd0, a_out_valid}, 64'd0);

    // Flush with the FIFO full
    a_out_ready = 1'b0;
    offer_a(32'h00100013, 3'd0, 64'h1, 1'b0, 1'b0, acc);
    offer_a(32'h00200013, 3'd0, 64'h2, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    flush = 1'b1; a_in_valid = 1'b1; a_instr = 32'h00900013; a_sel = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; a_in_valid = 1'b0;
    q_a.delete();
    @(negedge clk);
    check("a_flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("a_flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    a_out_ready = 1'b1;
    offer_a(32'hFFE00013, 3'd0, 64'hFFFFFFFE, 1'b0, 1'b1, acc);
    idle(3);

    // Reset mid-stream with the FIFO full
    a_out_ready = 1'b0;
    offer_a(32'h00300013, 3'd0, 64'h3, 1'b0, 1'b0, acc);
    offer_a(32'h00400013, 3'd0, 64'h4, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    check("a_in_ready_mid_rst", {63'd0, a_in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; a_in_valid = 1'b0;
    q_a.delete();
    @(negedge clk);
    check("a_rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("a_rst_out_imm", {32'd0, a_out_imm}, 64'd0);
    check("a_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    offer_a(32'h0AB00013, 3'd0, 64'h000000AB, 1'b0, 1'b1, acc);
    idle(2);

    // Bounded drain, then confirm nothing expected was lost
    for (int k = 0; k < 20 && (q_a.size() != 0 || q_b.size() != 0); k++) @(posedge clk);
    check("a_scoreboard_empty", 64'(q_a.size()), 64'd0);
    check("b_scoreboard_empty", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
